// File: rtl/apb_regbus_bridge_if.sv
// rtl/apb_regbus_bridge_if.sv - APB3 slave side plus regbus strobe side of the bridge.
interface apb_regbus_bridge_if #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;
  logic [ADDR_WIDTH-1:0]     addr;
  logic                      chip_select;
  logic                      write_en;
  logic                      read_en;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      data_valid;

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, read_data, data_valid,
    output prdata, pready, pslverr, addr, chip_select, write_en, read_en, write_data
  );

  modport master (
    output paddr, psel, penable, pwrite, pwdata, read_data, data_valid,
    input  prdata, pready, pslverr, addr, chip_select, write_en, read_en, write_data
  );
endinterface

// File: rtl/apb_regbus_bridge.sv
// rtl/apb_regbus_bridge.sv - APB3 slave turning each transfer into one regbus strobe, one wait state.
// Optional address/valid error reporting on pslverr when APB_REGBUS_SLVERR_EN is defined.
module apb_regbus_bridge #(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          ADDR_WIDTH     = 8,
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned MAX_ADDR       = 'h1C
) (
  input  logic                clk,
  input  logic                rst_n,
  apb_regbus_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  is_read_q, is_read_d;
  logic                  err_q, err_d;
  logic                  addr_err;

`ifdef APB_REGBUS_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;

  assign addr_err = (bus.paddr[1:0] != 2'b00)
                 || (bus.paddr[APB_ADDR_WIDTH-1:ADDR_WIDTH] != '0)
                 || (bus.paddr[ADDR_WIDTH-1:0] > ADDR_WIDTH'(MAX_ADDR));
`else
  localparam logic SLVERR_EN = 1'b0;
  logic unused_cfg;

  // Upper address bits and the map limit only matter to the error check.
  assign addr_err   = 1'b0;
  assign unused_cfg = ^{bus.paddr[APB_ADDR_WIDTH-1:ADDR_WIDTH], ADDR_WIDTH'(MAX_ADDR)};
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    is_read_d = is_read_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_d   = ISSUE;
          is_read_d = !bus.pwrite;
          err_d     = addr_err;
          if (!addr_err) begin
            addr_d  = bus.paddr[ADDR_WIDTH-1:0];
            wdata_d = bus.pwdata;
            cs_d    = 1'b1;
            we_d    = bus.pwrite;
            re_d    = !bus.pwrite;
          end
        end
      end
      ISSUE: begin
        // A dropped psel aborts without a response; the strobe already went out.
        if (!bus.psel) begin
          state_d = IDLE;
        end else begin
          state_d  = RESP;
          pready_d = 1'b1;
          if (err_q) begin
            prdata_d  = '0;
            pslverr_d = 1'b1;
          end else if (is_read_q) begin
            prdata_d  = bus.data_valid ? bus.read_data : '0;
            pslverr_d = SLVERR_EN && !bus.data_valid;
          end else begin
            prdata_d = '0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      re_q      <= re_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
    end
  end

  assign bus.prdata      = prdata_q;
  assign bus.pready      = pready_q;
  assign bus.pslverr     = pslverr_q;
  assign bus.addr        = addr_q;
  assign bus.chip_select = cs_q;
  assign bus.write_en    = we_q;
  assign bus.read_en     = re_q;
  assign bus.write_data  = wdata_q;

endmodule

// File: tb/tb_apb_regbus_bridge.sv
// tb/tb_apb_regbus_bridge.sv - directed bench for apb_regbus_bridge; expectations follow APB_REGBUS_SLVERR_EN.
module tb_apb_regbus_bridge;

`ifdef APB_REGBUS_SLVERR_EN
  localparam logic SLV = 1'b1;
`else
  localparam logic SLV = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  apb_regbus_bridge_if #(.APB_ADDR_WIDTH(12), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  apb_regbus_bridge #(
    .APB_ADDR_WIDTH(12),
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (32),
    .MAX_ADDR      ('h1C)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_prdata"}, bus.prdata, 32'h0);
    chk({tag, "_pready"}, {31'h0, bus.pready}, 32'h0);
    chk({tag, "_pslverr"}, {31'h0, bus.pslverr}, 32'h0);
    chk({tag, "_addr"}, {24'h0, bus.addr}, 32'h0);
    chk({tag, "_cs"}, {31'h0, bus.chip_select}, 32'h0);
    chk({tag, "_we"}, {31'h0, bus.write_en}, 32'h0);
    chk({tag, "_re"}, {31'h0, bus.read_en}, 32'h0);
    chk({tag, "_wdata"}, bus.write_data, 32'h0);
  endtask

  // Entered and left one time unit after a rising edge; setup occupies cycle N.
  task automatic xfer(input string tag, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic dv,
                      input logic exp_cs, input logic [7:0] exp_addr,
                      input logic [31:0] exp_prdata, input logic exp_err);
    bus.psel       = 1'b1;
    bus.penable    = 1'b0;
    bus.pwrite     = wr;
    bus.paddr      = a;
    bus.pwdata     = wd;
    bus.read_data  = rd;
    bus.data_valid = dv;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    chk({tag, "_n1_cs"}, {31'h0, bus.chip_select}, {31'h0, exp_cs});
    chk({tag, "_n1_we"}, {31'h0, bus.write_en}, {31'h0, exp_cs & wr});
    chk({tag, "_n1_re"}, {31'h0, bus.read_en}, {31'h0, exp_cs & ~wr});
    chk({tag, "_n1_pready"}, {31'h0, bus.pready}, 32'h0);
    if (exp_cs) chk({tag, "_n1_addr"}, {24'h0, bus.addr}, {24'h0, exp_addr});
    if (exp_cs && wr) chk({tag, "_n1_wdata"}, bus.write_data, wd);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_n2_pready"}, {31'h0, bus.pready}, 32'h1);
    chk({tag, "_n2_pslverr"}, {31'h0, bus.pslverr}, {31'h0, exp_err});
    chk({tag, "_n2_prdata"}, bus.prdata, exp_prdata);
    chk({tag, "_n2_cs"}, {31'h0, bus.chip_select}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.psel       = 1'b0;
    bus.penable    = 1'b0;
    bus.pwrite     = 1'b0;
    bus.paddr      = 12'h0;
    bus.pwdata     = 32'h0;
    bus.read_data  = 32'h0;
    bus.data_valid = 1'b0;
    #2;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer("wr000", 1'b1, 12'h000, 32'h0000_000B, 32'h0, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0);
    xfer("rd004", 1'b0, 12'h004, 32'h0, 32'h0000_0003, 1'b1, 1'b1, 8'h04, 32'h0000_0003, 1'b0);

    // psel+penable held in IDLE must not start a transfer.
    @(negedge clk);
    chk("ign_cs_a", {31'h0, bus.chip_select}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ign_cs_b", {31'h0, bus.chip_select}, 32'h0);
    chk("ign_pready", {31'h0, bus.pready}, 32'h0);
    chk("hold_prdata", bus.prdata, 32'h0000_0003);
    @(posedge clk); #1;
    idle_cycle();

    xfer("b2b_wr", 1'b1, 12'h014, 32'h0000_AA55, 32'h0, 1'b0, 1'b1, 8'h14, 32'h0, 1'b0);
    xfer("b2b_rd", 1'b0, 12'h014, 32'h0, 32'h0000_AA55, 1'b1, 1'b1, 8'h14, 32'h0000_AA55, 1'b0);
    idle_cycle();

    xfer("rd_nodv", 1'b0, 12'h00C, 32'h0, 32'h0000_DEAD, 1'b0, 1'b1, 8'h0C, 32'h0, SLV);
    idle_cycle();

    xfer("rd020", 1'b0, 12'h020, 32'h0, 32'h1234_5678, 1'b1, ~SLV, 8'h20,
         SLV ? 32'h0 : 32'h1234_5678, SLV);
    idle_cycle();
    xfer("rd006", 1'b0, 12'h006, 32'h0, 32'h8765_4321, 1'b1, ~SLV, 8'h06,
         SLV ? 32'h0 : 32'h8765_4321, SLV);
    idle_cycle();

    xfer("rd018", 1'b0, 12'h018, 32'h0, 32'h0000_5A5A, 1'b1, 1'b1, 8'h18, 32'h0000_5A5A, 1'b0);
    idle_cycle();

    // Reset pulsed while the strobe is out.
    bus.psel       = 1'b1;
    bus.penable    = 1'b0;
    bus.pwrite     = 1'b0;
    bus.paddr      = 12'h010;
    bus.read_data  = 32'h0000_1111;
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    chk("rst_issue_cs", {31'h0, bus.chip_select}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk); #1;
    rst_n       = 1'b1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge clk);
    chk("rst_after_pready", {31'h0, bus.pready}, 32'h0);
    chk("rst_after_cs", {31'h0, bus.chip_select}, 32'h0);
    @(posedge clk); #1;

    xfer("wr008", 1'b1, 12'h008, 32'h0000_0808, 32'h0, 1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    idle_cycle();

    // psel dropped during ISSUE.
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 12'h00C;
    bus.pwdata  = 32'h0000_0C0C;
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge clk);
    chk("drop_n1_cs", {31'h0, bus.chip_select}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_n2_pready", {31'h0, bus.pready}, 32'h0);
    chk("drop_n2_cs", {31'h0, bus.chip_select}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_n3_pready", {31'h0, bus.pready}, 32'h0);
    @(posedge clk); #1;

    xfer("rd01c", 1'b0, 12'h01C, 32'h0, 32'h1C1C_0001, 1'b1, 1'b1, 8'h1C, 32'h1C1C_0001, 1'b0);
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
